// File: rtl/fir_out_decim_if.sv
// Handshake bundle between the FIR output stage and its consumer.
// slave: the decimator side; master: the upstream/downstream environment.
interface fir_out_decim_if #(
    parameter int IN_W  = 29,
    parameter int OUT_W = 12
);
    logic             din_vld;
    logic [IN_W-1:0]  din;
    logic             dout_rdy;
    logic             ovf_clr;
    logic [OUT_W-1:0] dout;
    logic             dout_vld;
    logic             sat_pulse;
    logic             ovf_sticky;

    modport master (
        output din_vld, din, dout_rdy, ovf_clr,
        input  dout, dout_vld, sat_pulse, ovf_sticky
    );

    modport slave (
        input  din_vld, din, dout_rdy, ovf_clr,
        output dout, dout_vld, sat_pulse, ovf_sticky
    );
endinterface

// File: rtl/fir_out_decim.sv
// FIR output decimator: keeps every DECIM-th valid sample, rounds off SHIFT
// LSBs (round half up), limits to OUT_W bits and buffers the result in a
// show-ahead FIFO with registered outputs.
// Optional feature macro FIR_OUT_DECIM_SAT_EN: when defined, out-of-range
// results clamp and raise sat_pulse; when undefined, results wrap and
// sat_pulse stays 0.
// FIFO_DEPTH must be a power of two and at least 2.
module fir_out_decim #(
    parameter int DECIM      = 4,
    parameter int IN_W       = 29,
    parameter int OUT_W      = 12,
    parameter int SHIFT      = 17,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           rstn,
    fir_out_decim_if.slave bus
);
    localparam int SUM_W = IN_W + 1;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [SUM_W-1:0] RND = SUM_W'(1) << (SHIFT - 1);

    logic [PH_W-1:0]         phase;
    logic                    take;

    logic signed [SUM_W-1:0] s1_sum;
    logic                    s1_vld;

    logic signed [SUM_W-1:0] shifted;
    logic [SUM_W-OUT_W:0]    hi;
    logic                    ovr;
    logic [OUT_W-1:0]        res;
    logic                    res_sat;

    logic [OUT_W-1:0]        s2_data;
    logic                    s2_sat;
    logic                    s2_vld;

    logic [OUT_W-1:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_nxt;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        cnt_nxt;
    logic                    full;
    logic                    pop;
    logic                    wr_ok;
    logic                    ovf;
    logic [OUT_W-1:0]        head_nxt;

    assign take = bus.din_vld && (phase == '0);

    // Phase counter: advances on every valid input, wraps after DECIM-1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase <= '0;
        end else if (bus.din_vld) begin
            phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
        end
    end

    // Stage 1: sign-extend the accepted sample and add the half-LSB offset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= take;
        end
        if (take) begin
            s1_sum <= {bus.din[IN_W-1], bus.din} + RND;
        end
    end

    assign shifted = s1_sum >>> SHIFT;
    assign hi      = shifted[SUM_W-1:OUT_W-1];
    assign ovr     = !((&hi) || !(|hi));

`ifdef FIR_OUT_DECIM_SAT_EN
    // Stage 2 limiter: clamp to the signed OUT_W range.
    always_comb begin
        res     = shifted[OUT_W-1:0];
        res_sat = 1'b0;
        if (ovr) begin
            res_sat = 1'b1;
            res     = shifted[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic unused_ovr;
    assign unused_ovr = ovr;

    // Stage 2 limiter: plain wrap, keep the low OUT_W bits.
    always_comb begin
        res     = shifted[OUT_W-1:0];
        res_sat = 1'b0;
    end
`endif

    // Stage 2 register: requantized sample heading into the FIFO.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_vld <= 1'b0;
            s2_sat <= 1'b0;
        end else begin
            s2_vld <= s1_vld;
            s2_sat <= s1_vld && res_sat;
        end
        if (s1_vld) begin
            s2_data <= res;
        end
    end

    // dout_vld is registered from the next count, so it always equals count != 0.
    assign pop      = bus.dout_vld && bus.dout_rdy;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign wr_ok    = s2_vld && (!full || pop);
    assign ovf      = s2_vld && full && !pop;
    assign rd_nxt   = rd_ptr + PTR_W'(pop);
    assign cnt_nxt  = count + CNT_W'(wr_ok) - CNT_W'(pop);
    // When nothing else remains after the pop, the incoming write becomes the head.
    assign head_nxt = ((count - CNT_W'(pop)) == '0) ? s2_data : mem[rd_nxt];

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (rstn && wr_ok) begin
            mem[wr_ptr] <= s2_data;
        end
    end

    // FIFO pointers, registered show-ahead head and status flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            bus.dout       <= '0;
            bus.dout_vld   <= 1'b0;
            bus.sat_pulse  <= 1'b0;
            bus.ovf_sticky <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr         <= rd_nxt;
            count          <= cnt_nxt;
            bus.dout_vld   <= (cnt_nxt != '0);
            bus.dout       <= (cnt_nxt != '0) ? head_nxt : '0;
            bus.sat_pulse  <= wr_ok && s2_sat;
            bus.ovf_sticky <= ovf || (bus.ovf_sticky && !bus.ovf_clr);
        end
    end
endmodule
